// File: rtl/interrupt_ack_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_ack_sequencer_pkg
// Purpose  : Shared definitions for the 8259A acknowledge/poll control path.
//            Holds the control-state encoding used by the sequencer and by the
//            interrupt-control-signal logic, the 8080 CALL opcode, and a helper
//            that turns a one-hot level into its 3-bit binary code.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_ack_sequencer_pkg;

    localparam int CTL_STATE_W = 3;

    // Encoding is shared with the interrupt-control-signal logic; do not renumber.
    typedef enum logic [CTL_STATE_W-1:0] {
        CTL_READY = 3'd0,
        ACK1      = 3'd1,
        ACK2      = 3'd2,
        ACK3      = 3'd3,
        POLL      = 3'd4
    } ctl_state_t;

    // First byte returned in 8080/85 mode: CALL opcode.
    localparam logic [7:0] C_CALL_OPCODE = 8'hCD;

    // Level loaded when an acknowledge finds no pending request (spurious IR7).
    localparam logic [7:0] C_SPURIOUS_LEVEL = 8'h80;

    // Binary index of a one-hot level. Returns 0 for an all-zero input.
    function automatic logic [2:0] level_code(input logic [7:0] onehot);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_ack_sequencer_ack_vector_mux.sv
`default_nettype none
// ============================================================================
// Module   : ack_vector_mux
// Purpose  : Combinational selection of the byte returned on the internal data
//            bus for each acknowledge state and for a poll read.
// Ports    : state                      - current control state
//            u8086_mode                 - 1 = 8086, 0 = 8080/85
//            call_address_interval_4    - ADI (8080 mode only)
//            interrupt_vector_address   - A15..A5 from ICW1/ICW2
//            level                      - binary code of the latched level
//            poll_flag                  - a level was latched for the poll
//            vector_byte                - selected byte (unqualified by enable)
// Revision : 1.0 - initial release
// ============================================================================
module ack_vector_mux
    import interrupt_ack_sequencer_pkg::*;
(
    input  ctl_state_t  state,
    input  logic        u8086_mode,
    input  logic        call_address_interval_4,
    input  logic [10:0] interrupt_vector_address,
    input  logic [2:0]  level,
    input  logic        poll_flag,
    output logic [7:0]  vector_byte
);

    always_comb begin
        vector_byte = 8'h00;
        case (state)
            ACK1: begin
                // 8086 mode returns nothing on the first pulse.
                vector_byte = u8086_mode ? 8'h00 : C_CALL_OPCODE;
            end
            ACK2: begin
                if (u8086_mode) begin
                    vector_byte = {interrupt_vector_address[10:6], level};
                end else if (call_address_interval_4) begin
                    vector_byte = {interrupt_vector_address[2:0], level, 2'b00};
                end else begin
                    vector_byte = {interrupt_vector_address[2:1], level, 3'b000};
                end
            end
            ACK3: begin
                vector_byte = interrupt_vector_address[10:3];
            end
            POLL: begin
                vector_byte = {poll_flag, 4'b0000, level};
            end
            default: begin
                vector_byte = 8'h00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_ack_sequencer
// Purpose  : 8259A control state machine. Sequences INTA# acknowledge cycles
//            (8086 and 8080/85 modes) and OCW3 poll reads, emits the ISR latch
//            and end-of-sequence pulses, and drives vector/CALL/poll bytes.
// Ports    : clock, reset                     - clock, sync active-high reset
//            write_initial_command_word_1     - ICW1 strobe, aborts sequence
//            interrupt_acknowledge_n          - synchronized INTA#
//            read                             - decoded CS&RD level
//            poll_command                     - OCW3 poll pulse
//            u8086_or_mcs80_config            - 1 = 8086 mode
//            call_address_interval_4          - ADI
//            interrupt_vector_address[10:0]   - vector address bits
//            cascade_slave/_enable            - cascade bus gating
//            highest_level_in_request[7:0]    - one-hot winning request
//            control_state/next_control_state - registered / combinational state
//            latch_in_service, end_of_acknowledge_sequence,
//            end_of_poll_command              - one-cycle pulses
//            interrupt[7:0]                   - latched one-hot level
//            data_bus_out[7:0], data_bus_out_enable - internal bus drive
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_initial_command_word_1,
    input  logic               interrupt_acknowledge_n,
    input  logic               read,
    input  logic               poll_command,
    input  logic               u8086_or_mcs80_config,
    input  logic               call_address_interval_4,
    input  logic [10:0]        interrupt_vector_address,
    input  logic               cascade_slave,
    input  logic               cascade_slave_enable,
    input  logic [7:0]         highest_level_in_request,
    output logic [STATE_W-1:0] control_state,
    output logic [STATE_W-1:0] next_control_state,
    output logic               latch_in_service,
    output logic               end_of_acknowledge_sequence,
    output logic               end_of_poll_command,
    output logic [7:0]         interrupt,
    output logic [7:0]         data_bus_out,
    output logic               data_bus_out_enable
);

    ctl_state_t r_state;
    ctl_state_t w_next_state;
    logic       r_inta_d;
    logic       r_read_d;
    logic [7:0] r_interrupt;

    logic       w_abort;
    logic       w_inta_nedge;
    logic       w_inta_pedge;
    logic       w_read_pedge;
    logic       w_read_nedge;
    logic       w_latch;
    logic       w_latch_poll;
    logic       w_end_ack;
    logic       w_end_poll;
    logic       w_drive;
    logic       w_enable;
    logic [7:0] w_vector_byte;

    // ICW1 behaves exactly like reset and overrides every same-cycle event.
    assign w_abort      = reset | write_initial_command_word_1;

    assign w_inta_nedge =  r_inta_d & ~interrupt_acknowledge_n;
    assign w_inta_pedge = ~r_inta_d &  interrupt_acknowledge_n;
    assign w_read_pedge = ~r_read_d &  read;
    assign w_read_nedge =  r_read_d & ~read;

    // Next-state and pulse decode. Pulses are combinational from the edge so
    // they line up with the cycle in which the transition is taken.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_latch_poll = 1'b0;
        w_end_ack    = 1'b0;
        w_end_poll   = 1'b0;
        if (w_abort) begin
            w_next_state = CTL_READY;
        end else begin
            case (r_state)
                CTL_READY: begin
                    // INTA wins over a poll command arriving in the same cycle.
                    if (w_inta_nedge) begin
                        w_next_state = ACK1;
                        w_latch      = 1'b1;
                    end else if (poll_command) begin
                        w_next_state = POLL;
                    end
                end
                ACK1: begin
                    if (w_inta_nedge) begin
                        w_next_state = ACK2;
                    end
                end
                ACK2: begin
                    if (u8086_or_mcs80_config) begin
                        if (w_inta_pedge) begin
                            w_next_state = CTL_READY;
                            w_end_ack    = 1'b1;
                        end
                    end else if (w_inta_nedge) begin
                        w_next_state = ACK3;
                    end
                end
                ACK3: begin
                    if (w_inta_pedge) begin
                        w_next_state = CTL_READY;
                        w_end_ack    = 1'b1;
                    end
                end
                POLL: begin
                    if (w_read_pedge) begin
                        w_latch      = 1'b1;
                        w_latch_poll = 1'b1;
                    end
                    if (w_read_nedge) begin
                        w_next_state = CTL_READY;
                        w_end_poll   = 1'b1;
                    end
                end
                default: begin
                    w_next_state = CTL_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_abort) begin
            r_state     <= CTL_READY;
            r_inta_d    <= 1'b1;
            r_read_d    <= 1'b0;
            r_interrupt <= 8'h00;
        end else begin
            r_state  <= w_next_state;
            r_inta_d <= interrupt_acknowledge_n;
            r_read_d <= read;
            if (w_latch) begin
                // With nothing pending an acknowledge reports IR7, a poll reports none.
                if (highest_level_in_request == 8'h00) begin
                    r_interrupt <= w_latch_poll ? 8'h00 : C_SPURIOUS_LEVEL;
                end else begin
                    r_interrupt <= highest_level_in_request;
                end
            end else if (w_next_state == CTL_READY) begin
                r_interrupt <= 8'h00;
            end
        end
    end

    ack_vector_mux u_ack_vector_mux (
        .state                    (r_state),
        .u8086_mode               (u8086_or_mcs80_config),
        .call_address_interval_4  (call_address_interval_4),
        .interrupt_vector_address (interrupt_vector_address),
        .level                    (level_code(r_interrupt)),
        .poll_flag                (|r_interrupt),
        .vector_byte              (w_vector_byte)
    );

    // Drive only while the CPU is actually reading: INTA# low in an acknowledge
    // state (never on the 8086 first pulse) or RD high during a poll. A slave
    // whose ID is not on the cascade lines must stay off the bus.
    always_comb begin
        w_drive = 1'b0;
        case (r_state)
            ACK1:       w_drive = ~interrupt_acknowledge_n & ~u8086_or_mcs80_config;
            ACK2, ACK3: w_drive = ~interrupt_acknowledge_n;
            POLL:       w_drive = read;
            default:    w_drive = 1'b0;
        endcase
    end

    assign w_enable = w_drive & ~(cascade_slave & ~cascade_slave_enable) & ~w_abort;

    assign control_state               = STATE_W'(r_state);
    assign next_control_state          = STATE_W'(w_next_state);
    assign latch_in_service            = w_latch;
    assign end_of_acknowledge_sequence = w_end_ack;
    assign end_of_poll_command         = w_end_poll;
    assign interrupt                   = r_interrupt;
    assign data_bus_out_enable         = w_enable;
    assign data_bus_out                = w_enable ? w_vector_byte : 8'h00;

endmodule
`default_nettype wire
